// File: rtl/hazard_unit.sv
// Pipeline hazard responder: load-use stall, PC-write drain, branch flush and E-stage operand forwarding.
// Stall/flush/forward outputs are combinational in the cycle the hazard is seen; FSM and counters are registered.
module hazard_unit #(
   parameter int CNT_W = 16
) (
   input  logic             clk_i,
   input  logic             reset_ni,
   input  logic [3:0]       RA1D_i,
   input  logic [3:0]       RA2D_i,
   input  logic [3:0]       WA3D_i,
   input  logic             MemtoRegE_i,
   input  logic             RegWriteM_i,
   input  logic             RegWriteW_i,
   input  logic             PCSrcW_i,
   input  logic             PCWrPendingF_i,
   input  logic             BranchTakenD_i,
   input  logic             CntClr_i,
   output logic             StallF_o,
   output logic             StallD_o,
   output logic             FlushD_o,
   output logic             FlushE_o,
   output logic [1:0]       ForwardAE_o,
   output logic [1:0]       ForwardBE_o,
   output logic [1:0]       HazState_o,
   output logic [CNT_W-1:0] StallCount_o,
   output logic [CNT_W-1:0] FlushCount_o
);

   typedef enum logic [1:0] {
      RUN      = 2'b00,
      LD_STALL = 2'b01,
      PC_DRAIN = 2'b10
   } state_e;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [3:0]       ra1e_q, ra2e_q, wa3e_q, wa3m_q, wa3w_q;
   logic [3:0]       ra1e_d, ra2e_d, wa3e_d;
   state_e           state_q, state_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
   logic             ldr_stall;

   assign ldr_stall = MemtoRegE_i & ((RA1D_i == wa3e_q) | (RA2D_i == wa3e_q));

   assign StallF_o = ldr_stall | PCWrPendingF_i;
   assign StallD_o = ldr_stall;
   assign FlushD_o = PCWrPendingF_i | PCSrcW_i | BranchTakenD_i;
   assign FlushE_o = ldr_stall | BranchTakenD_i;

   // M-stage result is younger than W, so it wins when both match
   always_comb begin
      ForwardAE_o = 2'b00;
      if (RegWriteM_i && (ra1e_q == wa3m_q)) begin
         ForwardAE_o = 2'b10;
      end else if (RegWriteW_i && (ra1e_q == wa3w_q)) begin
         ForwardAE_o = 2'b01;
      end
      ForwardBE_o = 2'b00;
      if (RegWriteM_i && (ra2e_q == wa3m_q)) begin
         ForwardBE_o = 2'b10;
      end else if (RegWriteW_i && (ra2e_q == wa3w_q)) begin
         ForwardBE_o = 2'b01;
      end
   end

   always_comb begin
      ra1e_d = FlushE_o ? 4'd0 : RA1D_i;
      ra2e_d = FlushE_o ? 4'd0 : RA2D_i;
      wa3e_d = FlushE_o ? 4'd0 : WA3D_i;
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         ra1e_q <= 4'd0;
         ra2e_q <= 4'd0;
         wa3e_q <= 4'd0;
         wa3m_q <= 4'd0;
         wa3w_q <= 4'd0;
      end else begin
         ra1e_q <= ra1e_d;
         ra2e_q <= ra2e_d;
         wa3e_q <= wa3e_d;
         wa3m_q <= wa3e_q;
         wa3w_q <= wa3m_q;
      end
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q <= RUN;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         RUN: begin
            if (PCWrPendingF_i)  state_d = PC_DRAIN;
            else if (ldr_stall)  state_d = LD_STALL;
         end
         LD_STALL: begin
            state_d = PCWrPendingF_i ? PC_DRAIN : RUN;
         end
         PC_DRAIN: begin
            if (PCSrcW_i && !PCWrPendingF_i) state_d = RUN;
         end
         default: state_d = RUN;
      endcase
   end

   always_comb begin
      HazState_o = state_q;
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (CntClr_i) begin
         stall_cnt_d = '0;
         flush_cnt_d = '0;
      end else begin
         if (StallF_o && (stall_cnt_q != CNT_MAX)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
         if (FlushE_o && (flush_cnt_q != CNT_MAX)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign StallCount_o = stall_cnt_q;
   assign FlushCount_o = flush_cnt_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: per-cycle vector table through an expected-value queue, plus
// hand sequences for counter saturation/clear and an asynchronous reset mid-run.
module tb_hazard_unit;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset_n;
   logic [3:0] ra1d, ra2d, wa3d;
   logic       mtr_e, rw_m, rw_w, pcsrc_w, pcwr_pend, br_taken, cnt_clr;

   logic        stall_f, stall_d, flush_d, flush_e;
   logic [1:0]  fwd_a, fwd_b, haz;
   logic [15:0] sc, fc;

   logic        s_stall_f, s_stall_d, s_flush_d, s_flush_e;
   logic [1:0]  s_fwd_a, s_fwd_b, s_haz;
   logic [1:0]  s_sc, s_fc;

   int errors = 0;
   int checks = 0;

   hazard_unit u_dut (
      .clk_i(clk), .reset_ni(reset_n),
      .RA1D_i(ra1d), .RA2D_i(ra2d), .WA3D_i(wa3d),
      .MemtoRegE_i(mtr_e), .RegWriteM_i(rw_m), .RegWriteW_i(rw_w),
      .PCSrcW_i(pcsrc_w), .PCWrPendingF_i(pcwr_pend), .BranchTakenD_i(br_taken),
      .CntClr_i(cnt_clr),
      .StallF_o(stall_f), .StallD_o(stall_d), .FlushD_o(flush_d), .FlushE_o(flush_e),
      .ForwardAE_o(fwd_a), .ForwardBE_o(fwd_b), .HazState_o(haz),
      .StallCount_o(sc), .FlushCount_o(fc)
   );

   hazard_unit #(.CNT_W(2)) u_sat (
      .clk_i(clk), .reset_ni(reset_n),
      .RA1D_i(ra1d), .RA2D_i(ra2d), .WA3D_i(wa3d),
      .MemtoRegE_i(mtr_e), .RegWriteM_i(rw_m), .RegWriteW_i(rw_w),
      .PCSrcW_i(pcsrc_w), .PCWrPendingF_i(pcwr_pend), .BranchTakenD_i(br_taken),
      .CntClr_i(cnt_clr),
      .StallF_o(s_stall_f), .StallD_o(s_stall_d), .FlushD_o(s_flush_d), .FlushE_o(s_flush_e),
      .ForwardAE_o(s_fwd_a), .ForwardBE_o(s_fwd_b), .HazState_o(s_haz),
      .StallCount_o(s_sc), .FlushCount_o(s_fc)
   );

   typedef struct {
      int ra1d, ra2d, wa3d;
      int mtr, rwm, rww, pcs, pend, br, clr;
      int sf, sd, fd, fe, fa, fb, hz, sc, fc;
   } vec_t;

   vec_t tbl[26];
   vec_t exp_q[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, expv);
      end
   endtask

   function automatic int sat3(input int v);
      return (v > 3) ? 3 : v;
   endfunction

   task automatic drive(input int a, b, c, mtr, rwm, rww, pcs, pend, br, clr);
      @(posedge clk);
      #1;
      ra1d = a[3:0]; ra2d = b[3:0]; wa3d = c[3:0];
      mtr_e = mtr[0]; rw_m = rwm[0]; rw_w = rww[0];
      pcsrc_w = pcs[0]; pcwr_pend = pend[0]; br_taken = br[0]; cnt_clr = clr[0];
   endtask

   task automatic check_vec(input int i, input vec_t e);
      logic [31:0] s_act, s_exp;
      chk($sformatf("c%0d StallF", i), 32'(stall_f), e.sf);
      chk($sformatf("c%0d StallD", i), 32'(stall_d), e.sd);
      chk($sformatf("c%0d FlushD", i), 32'(flush_d), e.fd);
      chk($sformatf("c%0d FlushE", i), 32'(flush_e), e.fe);
      chk($sformatf("c%0d ForwardAE", i), 32'(fwd_a), e.fa);
      chk($sformatf("c%0d ForwardBE", i), 32'(fwd_b), e.fb);
      chk($sformatf("c%0d HazState", i), 32'(haz), e.hz);
      chk($sformatf("c%0d StallCount", i), 32'(sc), e.sc);
      chk($sformatf("c%0d FlushCount", i), 32'(fc), e.fc);
      chk($sformatf("c%0d sat StallCount", i), 32'(s_sc), sat3(e.sc));
      chk($sformatf("c%0d sat FlushCount", i), 32'(s_fc), sat3(e.fc));
      s_act = 32'({s_stall_f, s_stall_d, s_flush_d, s_flush_e, s_fwd_a, s_fwd_b, s_haz});
      s_exp = (e.sf << 9) | (e.sd << 8) | (e.fd << 7) | (e.fe << 6) | (e.fa << 4) | (e.fb << 2) | e.hz;
      chk($sformatf("c%0d sat controls", i), s_act, s_exp);
   endtask

   // A load in E is flushed by the stall, so LD_STALL must never see a second load-use
   always @(negedge clk) begin
      if (reset_n === 1'b1 && haz === 2'b01) begin
         chk("LD_STALL no repeat stall", 32'(stall_d), 32'd0);
      end
   end

   initial begin
      vec_t e;
      //            ra1 ra2 wa3 mtr rwm rww pcs pnd br clr  sf sd fd fe  fa fb hz  sc fc
      tbl[0]  = '{ 1, 2, 1,  0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0,  0, 0};
      tbl[1]  = '{ 3, 4, 2,  0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0,  0, 0};
      tbl[2]  = '{ 1, 2, 5,  0, 1, 1, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0,  0, 0};
      tbl[3]  = '{ 5, 2, 3,  0, 1, 1, 0, 0, 0, 0,  0, 0, 0, 0,  1, 2, 0,  0, 0};
      tbl[4]  = '{ 9, 9, 3,  0, 0, 1, 0, 0, 0, 0,  0, 0, 0, 0,  0, 1, 0,  0, 0};
      tbl[5]  = '{ 3, 5, 7,  0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0,  0, 0};
      tbl[6]  = '{ 0, 0, 4,  0, 1, 1, 0, 0, 0, 0,  0, 0, 0, 0,  2, 0, 0,  0, 0};
      tbl[7]  = '{ 8, 4, 6,  1, 0, 0, 0, 0, 0, 0,  1, 1, 0, 1,  0, 0, 0,  0, 0};
      tbl[8]  = '{ 8, 4, 6,  0, 1, 0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 1,  1, 1};
      tbl[9]  = '{ 0, 0, 0,  0, 0, 1, 0, 0, 0, 0,  0, 0, 0, 0,  0, 1, 0,  1, 1};
      tbl[10] = '{ 0, 0, 0,  0, 0, 0, 0, 0, 1, 0,  0, 0, 1, 1,  0, 0, 0,  1, 1};
      tbl[11] = '{ 0, 0, 0,  0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0,  1, 2};
      tbl[12] = '{ 0, 0, 0,  0, 0, 0, 0, 1, 0, 0,  1, 0, 1, 0,  0, 0, 0,  1, 2};
      tbl[13] = '{ 0, 0, 0,  0, 0, 0, 0, 1, 0, 0,  1, 0, 1, 0,  0, 0, 2,  2, 2};
      tbl[14] = '{ 0, 0, 0,  0, 0, 0, 0, 1, 0, 0,  1, 0, 1, 0,  0, 0, 2,  3, 2};
      tbl[15] = '{ 0, 0, 0,  0, 0, 0, 1, 0, 0, 0,  0, 0, 1, 0,  0, 0, 2,  4, 2};
      tbl[16] = '{ 0, 0, 0,  0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0,  4, 2};
      tbl[17] = '{ 0, 9, 0,  1, 0, 0, 0, 1, 0, 0,  1, 1, 1, 1,  0, 0, 0,  4, 2};
      tbl[18] = '{ 0, 0, 0,  0, 0, 0, 1, 1, 0, 0,  1, 0, 1, 0,  0, 0, 2,  5, 3};
      tbl[19] = '{ 0, 0, 0,  0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 2,  6, 3};
      tbl[20] = '{ 0, 0, 0,  0, 0, 0, 1, 0, 0, 0,  0, 0, 1, 0,  0, 0, 2,  6, 3};
      tbl[21] = '{ 0, 0, 0,  0, 0, 0, 0, 0, 1, 1,  0, 0, 1, 1,  0, 0, 0,  6, 3};
      tbl[22] = '{ 1, 0, 0,  1, 0, 0, 0, 0, 0, 0,  1, 1, 0, 1,  0, 0, 0,  0, 0};
      tbl[23] = '{ 0, 0, 0,  0, 0, 0, 0, 1, 0, 0,  1, 0, 1, 0,  0, 0, 1,  1, 1};
      tbl[24] = '{ 0, 0, 0,  0, 0, 0, 1, 0, 0, 0,  0, 0, 1, 0,  0, 0, 2,  2, 1};
      tbl[25] = '{ 0, 0, 0,  0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0,  2, 1};

      ra1d = 4'd0; ra2d = 4'd0; wa3d = 4'd0;
      mtr_e = 1'b0; rw_m = 1'b0; rw_w = 1'b0;
      pcsrc_w = 1'b0; pcwr_pend = 1'b0; br_taken = 1'b0; cnt_clr = 1'b0;
      reset_n = 1'b1;
      #1 reset_n = 1'b0;
      #1;
      chk("reset HazState", 32'(haz), 32'd0);
      chk("reset StallCount", 32'(sc), 32'd0);
      chk("reset FlushCount", 32'(fc), 32'd0);
      chk("reset ForwardAE", 32'(fwd_a), 32'd0);
      chk("reset StallF", 32'(stall_f), 32'd0);
      #10 reset_n = 1'b1;

      for (int i = 0; i < 26; i++) begin
         drive(tbl[i].ra1d, tbl[i].ra2d, tbl[i].wa3d, tbl[i].mtr, tbl[i].rwm, tbl[i].rww,
               tbl[i].pcs, tbl[i].pend, tbl[i].br, tbl[i].clr);
         exp_q.push_back(tbl[i]);
         @(negedge clk);
         e = exp_q.pop_front();
         check_vec(i, e);
      end

      // Saturation on the 2-bit instance: clear, then hold StallF for six cycles
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      for (int i = 1; i <= 6; i++) begin
         drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
         @(negedge clk);
         chk($sformatf("sat run%0d StallCount", i), 32'(s_sc), sat3(i - 1));
         chk($sformatf("wide run%0d StallCount", i), 32'(sc), i - 1);
      end
      drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
      @(negedge clk);
      chk("sat held StallCount", 32'(s_sc), 32'd3);
      chk("wide held StallCount", 32'(sc), 32'd6);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      chk("sat clr-over-inc StallCount", 32'(s_sc), 32'd0);
      chk("wide clr-over-inc StallCount", 32'(sc), 32'd0);
      chk("drain holds without PCSrcW", 32'(haz), 32'd2);

      // Asynchronous reset mid-cycle with WA3M=5, RA1E=7, RegWriteM=1
      drive(0, 0, 5, 0, 0, 0, 0, 1, 0, 0);
      drive(7, 7, 0, 0, 0, 0, 0, 1, 0, 0);
      drive(0, 0, 0, 0, 1, 0, 0, 1, 0, 0);
      @(negedge clk);
      chk("pre-reset ForwardAE", 32'(fwd_a), 32'd0);
      chk("pre-reset HazState", 32'(haz), 32'd2);
      chk("pre-reset StallCount", 32'(sc), 32'd2);
      #1 reset_n = 1'b0;
      #1;
      chk("mid-reset ForwardAE", 32'(fwd_a), 32'd2);
      chk("mid-reset ForwardBE", 32'(fwd_b), 32'd2);
      chk("mid-reset HazState", 32'(haz), 32'd0);
      chk("mid-reset StallCount", 32'(sc), 32'd0);
      chk("mid-reset FlushCount", 32'(fc), 32'd0);
      chk("mid-reset sat StallCount", 32'(s_sc), 32'd0);
      chk("mid-reset StallF", 32'(stall_f), 32'd1);
      #1 reset_n = 1'b1;
      @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
